wb_scoreboard_arbiter: RTL and testbench

- Write-side master for the 32x32 integer register file: it generates the register file's write address, write data and write enable.
- Arbitrates between the single-cycle pipeline result and the multi-cycle M-extension (MUL/DIV) result using a valid/ready handshake.
- Keeps a per-register busy scoreboard for long-latency destinations and tells issue logic when source/destination registers are hazardous.
- Sits between execute/M-unit and the register file write port.

---
 rtl/wb_scoreboard_arbiter_pkg.sv | 35 +++
 rtl/wb_scoreboard_arbiter_scoreboard_bits.sv | 63 ++++++
 rtl/wb_scoreboard_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_scoreboard_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_arbiter_pkg.sv
// Shared RV32 integer register-file types for the write-back arbiter.
// Address/data widths, the x0 index and the write-port bundle.
package wb_scoreboard_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [NUM_REGS-1:0]   reg_vec_t;

  localparam reg_addr_t X0 = '0;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    xlen_t     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_LONG
  } wb_src_t;

  // x0 maps to an all-zero mask so it can never be marked busy.
  function automatic reg_vec_t reg_onehot(input reg_addr_t a);
    reg_vec_t v;
    v = '0;
    if (a != X0) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_scoreboard_arbiter_scoreboard_bits.sv
// Busy bit per integer register plus the outstanding long-op counter.
// Set beats clear on the same register; the counter saturates at zero.
module wb_scoreboard_arbiter_scoreboard_bits
  import wb_scoreboard_arbiter_pkg::*;
#(
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      set_req,
  input  reg_addr_t set_idx,
  input  logic      clr_en,
  input  reg_addr_t clr_idx,
  output reg_vec_t  busy,
  output logic      full,
  output logic      underflow
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  reg_vec_t         busy_next;
  reg_vec_t         set_mask;
  reg_vec_t         clr_mask;
  logic             set_en;

  assign full   = (count == CNT_W'(MAX_LONG));
  assign set_en = set_req & ~full;

  assign underflow = clr_en & ~set_en
                   & (count == '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = reg_onehot(set_idx);
    if (clr_en) clr_mask = reg_onehot(clr_idx);
    busy_next     = (busy & ~clr_mask) | set_mask;
    busy_next[X0] = 1'b0;
  end

  always_comb begin
    count_next = count;
    unique case (1'b1)
      set_en & ~clr_en:
        count_next = count + 1'b1;
      clr_en & ~set_en & (count != '0):
        count_next = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/wb_scoreboard_arbiter.sv
// Register-file write master: pipeline-over-M-unit arbitration,
// busy scoreboard for long-latency destinations and issue hazards.
module wb_scoreboard_arbiter
  import wb_scoreboard_arbiter_pkg::*;
#(
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  long_valid,
  output logic                  long_ready,
  input  logic [REG_ADDR_W-1:0] long_rd,
  input  logic [XLEN-1:0]       long_data,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  hazard,
  output logic                  long_full,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_waw
);

  wb_src_t src;
  wb_req_t wb_q;
  wb_req_t wb_next;
  logic    long_fire;
  logic    underflow;
  logic    pipe_waw;
  logic    long_stray;
  logic    sb_hit;
  logic    wb_hit;

  assign long_ready = ~pipe_valid;
  assign long_fire  = long_valid & long_ready;

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      pipe_valid: src = SRC_PIPE;
      long_fire:  src = SRC_LONG;
      default:    src = SRC_NONE;
    endcase
  end

  // Address/data hold when idle; only the enable drops.
  always_comb begin
    wb_next    = wb_q;
    wb_next.we = 1'b0;
    unique case (src)
      SRC_PIPE: begin
        wb_next.we   = (pipe_rd != X0);
        wb_next.addr = pipe_rd;
        wb_next.data = pipe_data;
      end
      SRC_LONG: begin
        wb_next.we   = (long_rd != X0);
        wb_next.addr = long_rd;
        wb_next.data = long_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_next;
  end

  assign wb_we   = wb_q.we;
  assign wb_addr = wb_q.addr;
  assign wb_data = wb_q.data;

  wb_scoreboard_arbiter_scoreboard_bits #(
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_req   (issue_valid & issue_long),
    .set_idx   (issue_rd),
    .clr_en    (long_fire),
    .clr_idx   (long_rd),
    .busy      (busy_vec),
    .full      (long_full),
    .underflow (underflow)
  );

  assign pipe_waw = pipe_valid
                  & (pipe_rd != X0)
                  & busy_vec[pipe_rd];

  assign long_stray = long_fire
                    & (long_rd != X0)
                    & ~busy_vec[long_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_waw <= 1'b0;
    else if (pipe_waw | long_stray | underflow)
      err_waw <= 1'b1;
  end

  // busy_vec[x0] is held at 0, so x0 queries never hit here.
  assign sb_hit = busy_vec[chk_rs1]
                | busy_vec[chk_rs2]
                | busy_vec[chk_rd];

  // Write is in flight to the array and not yet readable.
  assign wb_hit = wb_q.we & (
      ((chk_rs1 != X0) & (chk_rs1 == wb_q.addr))
    | ((chk_rs2 != X0) & (chk_rs2 == wb_q.addr)));

  assign hazard = sb_hit | wb_hit;

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Directed and randomized checks of wb_scoreboard_arbiter against
// a rule-level model of the scoreboard, counter and write port.
module tb_wb_scoreboard_arbiter;

  localparam int MAX_LONG = 2;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        long_valid;
  logic        long_ready;
  logic [4:0]  long_rd;
  logic [31:0] long_data;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        long_full;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;
  logic        err_waw;

  int total;
  int bad;

  bit [31:0]   m_busy;
  int          m_cnt;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  bit          p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;

  wb_scoreboard_arbiter #(.MAX_LONG(MAX_LONG), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_rd(long_rd), .long_data(long_data),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .long_full(long_full),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec), .err_waw(err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    long_valid = 0; long_rd = 0; long_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic m_reset();
    m_busy = 0; m_cnt = 0; m_err = 0;
    m_we = 0; m_addr = 0; m_data = 0;
    p_valid = 0;
  endtask

  function automatic bit exp_hazard();
    bit h;
    h = 0;
    if (chk_rs1 != 0 && m_busy[chk_rs1]) h = 1;
    if (chk_rs2 != 0 && m_busy[chk_rs2]) h = 1;
    if (chk_rd != 0 && m_busy[chk_rd]) h = 1;
    if (m_we && chk_rs1 != 0 && chk_rs1 == m_addr) h = 1;
    if (m_we && chk_rs2 != 0 && chk_rs2 == m_addr) h = 1;
    return h;
  endfunction

  // Apply the clock edge to the model, then to the DUT.
  task automatic tick();
    bit fire;
    bit acc;
    fire = long_valid && !pipe_valid;
    acc = issue_valid && issue_long && (m_cnt != MAX_LONG);
    if (pipe_valid && pipe_rd != 0 && m_busy[pipe_rd]) m_err = 1;
    if (fire && long_rd != 0 && !m_busy[long_rd]) m_err = 1;
    if (fire && !acc && m_cnt == 0) m_err = 1;
    if (pipe_valid) begin
      m_we = (pipe_rd != 0); m_addr = pipe_rd; m_data = pipe_data;
    end else if (fire) begin
      m_we = (long_rd != 0); m_addr = long_rd; m_data = long_data;
    end else begin
      m_we = 0;
    end
    if (fire) m_busy[long_rd] = 0;
    if (acc && issue_rd != 0) m_busy[issue_rd] = 1;
    m_cnt = m_cnt + int'(acc) - int'(fire);
    if (m_cnt < 0) m_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    m_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    m_reset();
    #3;
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    total++; if (err_waw !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_waw); end
    total++; if (long_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", long_full); end
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", long_ready); end
    @(posedge clk); #1;
    rst = 1;
    issue_valid = 1; issue_long = 1; issue_rd = 5;
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h1234;
    tick();
    clear_inputs();
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL midop_busy got=%h exp=20", busy_vec); end
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL midop_we got=%b exp=1", wb_we); end
    #2;
    rst = 0;
    #1;
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL async_busy got=%h exp=0", busy_vec); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL async_we got=%b exp=0", wb_we); end
    total++; if (long_full !== 1'b0) begin bad++; $display("FAIL async_full got=%b exp=0", long_full); end
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL async_ready got=%b exp=1", long_ready); end
    m_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_pipe();
    pipe_valid = 1; pipe_rd = 7; pipe_data = 32'hDEADBEEF;
    tick();
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL pipe_we got=%b exp=1", wb_we); end
    total++; if (wb_addr !== 5'd7) begin bad++; $display("FAIL pipe_addr got=%0d exp=7", wb_addr); end
    total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL pipe_data got=%h exp=deadbeef", wb_data); end
    pipe_rd = 0; pipe_data = 32'h55;
    tick();
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL pipe_x0_we got=%b exp=0", wb_we); end
    clear_inputs();
    tick();
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL pipe_idle_we got=%b exp=0", wb_we); end
  endtask

  task automatic test_long_flow();
    issue_valid = 1; issue_long = 1; issue_rd = 5;
    tick();
    clear_inputs();
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL long_busy got=%h exp=20", busy_vec); end
    chk_rs1 = 5; #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL long_haz_busy got=%b exp=1", hazard); end
    long_valid = 1; long_rd = 5; long_data = 42; #1;
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL long_ready got=%b exp=1", long_ready); end
    tick();
    long_valid = 0;
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL long_clr got=%h exp=0", busy_vec); end
    total++; if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'd42) begin
      bad++; $display("FAIL long_wb got=%b/%0d/%0d exp=1/5/42", wb_we, wb_addr, wb_data); end
    #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL long_haz_wb got=%b exp=1", hazard); end
    tick();
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL long_haz_off got=%b exp=0", hazard); end
    clear_inputs();
  endtask

  task automatic test_collision();
    issue_valid = 1; issue_long = 1; issue_rd = 11;
    tick();
    clear_inputs();
    pipe_valid = 1; pipe_rd = 10; pipe_data = 111;
    long_valid = 1; long_rd = 11; long_data = 222; #1;
    total++; if (long_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b exp=0", long_ready); end
    tick();
    total++; if (wb_addr !== 5'd10 || wb_data !== 32'd111) begin
      bad++; $display("FAIL coll_pipe got=%0d/%0d exp=10/111", wb_addr, wb_data); end
    total++; if (busy_vec !== 32'h800) begin bad++; $display("FAIL coll_hold got=%h exp=800", busy_vec); end
    pipe_valid = 0; #1;
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL coll_ready2 got=%b exp=1", long_ready); end
    tick();
    long_valid = 0;
    total++; if (wb_we !== 1'b1 || wb_addr !== 5'd11 || wb_data !== 32'd222) begin
      bad++; $display("FAIL coll_long got=%b/%0d/%0d exp=1/11/222", wb_we, wb_addr, wb_data); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL coll_clr got=%h exp=0", busy_vec); end
    clear_inputs();
  endtask

  task automatic test_full();
    issue_valid = 1; issue_long = 1; issue_rd = 3; tick();
    issue_rd = 4; tick();
    total++; if (long_full !== 1'b1 || busy_vec !== 32'h18) begin
      bad++; $display("FAIL full_set got=%b/%h exp=1/18", long_full, busy_vec); end
    issue_rd = 6; tick();
    total++; if (busy_vec !== 32'h18 || long_full !== 1'b1) begin
      bad++; $display("FAIL full_ignore got=%h/%b exp=18/1", busy_vec, long_full); end
    issue_valid = 0; issue_long = 0;
    long_valid = 1; long_rd = 4; long_data = 9; tick();
    total++; if (busy_vec !== 32'h08 || long_full !== 1'b0) begin
      bad++; $display("FAIL full_drain got=%h/%b exp=08/0", busy_vec, long_full); end
    issue_valid = 1; issue_long = 1; issue_rd = 3;
    long_rd = 3; tick();
    long_valid = 0;
    total++; if (busy_vec !== 32'h08 || long_full !== 1'b0) begin
      bad++; $display("FAIL setclr got=%h/%b exp=08/0", busy_vec, long_full); end
    issue_rd = 8; tick();
    total++; if (busy_vec !== 32'h108 || long_full !== 1'b1) begin
      bad++; $display("FAIL refill got=%h/%b exp=108/1", busy_vec, long_full); end
    clear_inputs();
    long_valid = 1; long_rd = 3; tick();
    long_rd = 8; tick();
    clear_inputs();
    total++; if (busy_vec !== 32'd0 || long_full !== 1'b0 || err_waw !== 1'b0) begin
      bad++; $display("FAIL full_end got=%h/%b/%b exp=0/0/0", busy_vec, long_full, err_waw); end
  endtask

  task automatic test_error();
    issue_valid = 1; issue_long = 1; issue_rd = 4; tick();
    clear_inputs();
    total++; if (err_waw !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", err_waw); end
    pipe_valid = 1; pipe_rd = 4; pipe_data = 77; tick();
    clear_inputs();
    total++; if (err_waw !== 1'b1 || wb_we !== 1'b1 || wb_addr !== 5'd4) begin
      bad++; $display("FAIL err_pipe got=%b/%b/%0d exp=1/1/4", err_waw, wb_we, wb_addr); end
    tick(); tick(); tick();
    total++; if (err_waw !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_waw); end
    do_reset();
    issue_valid = 1; issue_long = 1; issue_rd = 2; tick();
    clear_inputs();
    long_valid = 1; long_rd = 9; long_data = 5; tick();
    clear_inputs();
    total++; if (err_waw !== 1'b1 || busy_vec !== 32'h4) begin
      bad++; $display("FAIL err_stray got=%b/%h exp=1/4", err_waw, busy_vec); end
    do_reset();
  endtask

  task automatic test_random();
    bit fire;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) do_reset();
      pipe_valid = ($urandom % 100) < 30;
      pipe_rd = 5'($urandom_range(31));
      if (m_busy[pipe_rd] && ($urandom % 8) != 0) pipe_rd = 0;
      pipe_data = $urandom;
      issue_valid = ($urandom % 100) < 35;
      issue_long = ($urandom % 4) != 0;
      issue_rd = 5'($urandom_range(31));
      if (!p_valid && ($urandom % 100) < 45) begin
        p_valid = 1;
        p_data = $urandom;
        p_rd = 5'($urandom_range(31));
        if (m_busy != 0 && ($urandom % 8) != 0)
          while (!m_busy[p_rd]) p_rd = 5'($urandom_range(31));
      end
      long_valid = p_valid; long_rd = p_rd; long_data = p_data;
      chk_rs1 = 5'($urandom_range(31));
      chk_rs2 = ($urandom % 2) != 0 ? m_addr : 5'($urandom_range(31));
      chk_rd = 5'($urandom_range(31));
      #1;
      total++; if (long_ready !== !pipe_valid) begin
        bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, long_ready, !pipe_valid); end
      total++; if (hazard !== exp_hazard()) begin
        bad++; $display("FAIL rnd_hazard i=%0d got=%b exp=%b", i, hazard, exp_hazard()); end
      fire = p_valid && !pipe_valid;
      tick();
      if (fire) p_valid = 0;
      total++; if (wb_we !== m_we) begin
        bad++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, wb_we, m_we); end
      if (m_we) begin
        total++; if (wb_addr !== m_addr || wb_data !== m_data) begin
          bad++; $display("FAIL rnd_wb i=%0d got=%0d/%h exp=%0d/%h", i, wb_addr, wb_data, m_addr, m_data); end
      end
      total++; if (busy_vec !== m_busy) begin
        bad++; $display("FAIL rnd_busy i=%0d got=%h exp=%h", i, busy_vec, m_busy); end
      total++; if (long_full !== (m_cnt == MAX_LONG)) begin
        bad++; $display("FAIL rnd_full i=%0d got=%b cnt=%0d", i, long_full, m_cnt); end
      total++; if (err_waw !== m_err) begin
        bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err_waw, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_pipe();
    test_long_flow();
    test_collision();
    test_full();
    test_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
